// File: rtl/mult_pkg.sv
// Shared types and elaboration-time helpers for the pipelined multiplier.
package mult_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned MAX_PW    = 2 * MAX_WIDTH;

    // Carry-save pair sized for the widest legal operand; users take the low 2*WIDTH bits.
    typedef struct packed {
        logic [MAX_PW-1:0] sum;
        logic [MAX_PW-1:0] carry;
    } csa_pair_t;

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

    // WIDTH partial-product rows plus one correction-constant row.
    function automatic int unsigned csa_rows(input int unsigned w);
        return w + 1;
    endfunction

    // Baugh-Wooley constant: 2^w + 2^(2w-1), modulo 2^(2w).
    function automatic logic [MAX_PW-1:0] bw_correction(input int unsigned w);
        return (MAX_PW'(1) << w) | (MAX_PW'(1) << (2 * w - 1));
    endfunction

    // Largest Dadda height (2,3,4,6,9,13,19,28,42) strictly below h.
    function automatic int unsigned dadda_target(input int unsigned h);
        int unsigned d;
        int unsigned nxt;
        d   = 2;
        nxt = 3;
        while (nxt < h) begin
            d   = nxt;
            nxt = (nxt * 3) / 2;
        end
        return d;
    endfunction

endpackage

// File: rtl/mult_csa_tree.sv
// Combinational partial-product generation and carry-save compression to two rows.
module mult_csa_tree
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             signed_mode,
    output csa_pair_t        pair
);

    localparam int unsigned PW   = prod_width(WIDTH);
    localparam int unsigned ROWS = csa_rows(WIDTH);
    localparam logic [MAX_PW-1:0] CORR = bw_correction(WIDTH);

    logic [PW-1:0]    rows [ROWS];
    logic [PW-1:0]    nxt  [ROWS];
    logic [WIDTH-1:0] pp;
    int unsigned      h;
    int unsigned      d;
    int unsigned      n;

    always_comb begin
        pp = '0;
        h  = ROWS;
        d  = 0;
        n  = 0;
        for (int unsigned k = 0; k < ROWS; k++) nxt[k] = '0;
        // Signed mode inverts the terms where exactly one operand index is the MSB.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                pp[j] = x[j] & y[i];
                if (signed_mode && ((i == WIDTH - 1) != (j == WIDTH - 1)))
                    pp[j] = ~pp[j];
            end
            rows[i] = PW'(pp) << i;
        end
        rows[ROWS-1] = signed_mode ? CORR[PW-1:0] : '0;

        // Each level compresses only as many row triples as needed to reach the next Dadda height.
        while (h > 2) begin
            d = dadda_target(h);
            n = h - d;
            for (int unsigned k = 0; k < ROWS; k++) nxt[k] = '0;
            for (int unsigned k = 0; k < n; k++) begin
                nxt[2*k]   = rows[3*k] ^ rows[3*k+1] ^ rows[3*k+2];
                nxt[2*k+1] = ((rows[3*k] & rows[3*k+1]) | (rows[3*k] & rows[3*k+2])
                             | (rows[3*k+1] & rows[3*k+2])) << 1;
            end
            for (int unsigned k = 3 * n; k < h; k++) nxt[k-n] = rows[k];
            for (int unsigned k = 0; k < ROWS; k++) rows[k] = (k < d) ? nxt[k] : '0;
            h = d;
        end

        pair.sum   = MAX_PW'(rows[0]);
        pair.carry = MAX_PW'(rows[1]);
    end

endmodule

// File: rtl/mult_pipe_seq.sv
// Pipelined WIDTH x WIDTH multiplier with stall-all valid/ready flow control.
// Optional MULT_PIPE_CNT_EN adds a 32-bit count of output handshakes (done_count).
module mult_pipe_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product
`ifdef MULT_PIPE_CNT_EN
    ,
    output logic [31:0]          done_count
`endif
);

    localparam int unsigned PW   = prod_width(WIDTH);
    localparam int unsigned LVLS = $clog2(PW);

    logic                   adv;
    logic [PIPE_STAGES-1:0] vld;
    logic [WIDTH-1:0]       tx;
    logic [WIDTH-1:0]       ty;
    logic                   tsm;
    csa_pair_t              tree_pair;
    csa_pair_t              add_pair;
    logic [PW-1:0]          gen  [LVLS+1];
    logic [PW-1:0]          prop [LVLS+1];
    logic [PW-1:0]          sum;

    assign out_valid = vld[PIPE_STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (adv) begin
            vld[0] <= in_valid;
            for (int unsigned i = 1; i < PIPE_STAGES; i++) vld[i] <= vld[i-1];
        end
    end

    generate
        if (PIPE_STAGES == 1) begin : g_comb_in
            assign tx  = in_x;
            assign ty  = in_y;
            assign tsm = in_signed;
        end else begin : g_op_reg
            logic [WIDTH-1:0] x_q;
            logic [WIDTH-1:0] y_q;
            logic             sm_q;
            always_ff @(posedge clk) begin
                if (adv) begin
                    x_q  <= in_x;
                    y_q  <= in_y;
                    sm_q <= in_signed;
                end
            end
            assign tx  = x_q;
            assign ty  = y_q;
            assign tsm = sm_q;
        end
    endgenerate

    mult_csa_tree #(.WIDTH(WIDTH)) u_tree (
        .x           (tx),
        .y           (ty),
        .signed_mode (tsm),
        .pair        (tree_pair)
    );

    generate
        if (PIPE_STAGES >= 3) begin : g_cs_reg
            localparam int unsigned NCS = PIPE_STAGES - 2;
            csa_pair_t cs_q [NCS];
            always_ff @(posedge clk) begin
                if (adv) begin
                    cs_q[0] <= tree_pair;
                    for (int unsigned i = 1; i < NCS; i++) cs_q[i] <= cs_q[i-1];
                end
            end
            assign add_pair = cs_q[NCS-1];
        end else begin : g_cs_pass
            assign add_pair = tree_pair;
        end
    endgenerate

    // Kogge-Stone prefix: black cells combine (G,P); cells whose span reaches bit 0 only need G (grey).
    always_comb begin
        gen[0]  = add_pair.sum[PW-1:0] & add_pair.carry[PW-1:0];
        prop[0] = add_pair.sum[PW-1:0] ^ add_pair.carry[PW-1:0];
        for (int unsigned l = 0; l < LVLS; l++) begin
            for (int unsigned i = 0; i < PW; i++) begin
                if (i >= (32'd1 << l)) begin
                    gen[l+1][i]  = gen[l][i] | (prop[l][i] & gen[l][i-(32'd1 << l)]);
                    prop[l+1][i] = prop[l][i] & prop[l][i-(32'd1 << l)];
                end else begin
                    gen[l+1][i]  = gen[l][i];
                    prop[l+1][i] = prop[l][i];
                end
            end
        end
        sum = prop[0] ^ {gen[LVLS][PW-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_product <= '0;
        end else if (adv) begin
            out_product <= sum;
        end
    end

`ifdef MULT_PIPE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_count <= '0;
        end else if (out_valid && out_ready) begin
            done_count <= done_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_pipe_seq.sv
// Self-checking bench: four multiplier configurations share one random stimulus stream.
module tb_mult_pipe_seq;

    localparam int NI = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        in_signed;
    logic        end_chk;
    logic        tp_en;

    logic        ov_a   [NI];
    logic        rdy_a  [NI];
    logic [63:0] prod_a [NI];

    int checks;
    int failures;
    int tp_run;
    int tp_best;
    int tp_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Exact product of the low w bits of a and b, reduced to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input int w);
        longint      va;
        longint      vb;
        longint      m;
        logic [63:0] r;
        m  = (longint'(1) << w) - 1;
        va = longint'({32'b0, a}) & m;
        vb = longint'({32'b0, b}) & m;
        if (s) begin
            if (va[w-1]) va = va - (longint'(1) << w);
            if (vb[w-1]) vb = vb - (longint'(1) << w);
        end
        r = 64'(va * vb);
        return r & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_i
        localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 5 : 32;
        localparam int P = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4;

        logic           rdy;
        logic           ov;
        logic [2*W-1:0] prod;
        logic [P-1:0]   mv;
        logic [63:0]    mp [P];
        logic           madv;
        logic           hold_q;
        logic [2*W-1:0] held;
        int             acc_n;
        int             emit_n;
`ifdef MULT_PIPE_CNT_EN
        logic [31:0]    dc;
        logic [31:0]    mcnt;
`endif

        mult_pipe_seq #(.WIDTH(W), .PIPE_STAGES(P)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid),
            .in_ready    (rdy),
            .in_x        (in_x[W-1:0]),
            .in_y        (in_y[W-1:0]),
            .in_signed   (in_signed),
            .out_valid   (ov),
            .out_ready   (out_ready),
            .out_product (prod)
`ifdef MULT_PIPE_CNT_EN
            ,
            .done_count  (dc)
`endif
        );

        assign ov_a[g]   = ov;
        assign rdy_a[g]  = rdy;
        assign prod_a[g] = 64'(prod);

        // Reference: P slots that all shift together whenever the output slot is empty or consumed.
        assign madv = !mv[P-1] || out_ready;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mv     <= '0;
                acc_n  <= 0;
                emit_n <= 0;
            end else begin
                if (madv) begin
                    mv[0] <= in_valid;
                    mp[0] <= ref_mul(in_x, in_y, in_signed, W);
                    for (int i = 1; i < P; i++) begin
                        mv[i] <= mv[i-1];
                        mp[i] <= mp[i-1];
                    end
                end
                if (in_valid && madv) acc_n <= acc_n + 1;
                if (ov && out_ready) emit_n <= emit_n + 1;
            end
        end

`ifdef MULT_PIPE_CNT_EN
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) mcnt <= '0;
            else if (mv[P-1] && out_ready) mcnt <= mcnt + 32'd1;
        end
`endif

        always @(negedge clk) begin
            if (!rst_n) begin
                hold_q = 1'b0;
            end else begin
                check($sformatf("g%0d in_ready", g), 64'(rdy), 64'(madv));
                check($sformatf("g%0d out_valid", g), 64'(ov), 64'(mv[P-1]));
                if (mv[P-1]) check($sformatf("g%0d out_product", g), 64'(prod), mp[P-1]);
                if (hold_q) check($sformatf("g%0d stall hold", g), 64'(prod), 64'(held));
`ifdef MULT_PIPE_CNT_EN
                check($sformatf("g%0d done_count", g), 64'(dc), 64'(mcnt));
`endif
                hold_q = ov && !out_ready;
                held   = prod;
            end
        end

        always @(posedge end_chk) begin
            check($sformatf("g%0d emitted vs accepted", g), 64'(emit_n), 64'(acc_n));
        end
    end

    always @(negedge clk) begin
        if (tp_en) begin
            if (ov_a[1]) begin
                tp_run++;
                tp_total++;
            end else begin
                if (tp_run > tp_best) tp_best = tp_run;
                tp_run = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_signed = s;
        step();
        in_valid  = 1'b0;
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [63:0] p;
    } vec_t;

    vec_t v4 [6];

    initial begin
        checks    = 0;
        failures  = 0;
        tp_run    = 0;
        tp_best   = 0;
        tp_total  = 0;
        tp_en     = 1'b0;
        end_chk   = 1'b0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_x      = '0;
        in_y      = '0;
        in_signed = 1'b0;

        v4[0] = '{32'd15, 32'd9 + 32'd6, 1'b0, 64'h00E1};
        v4[1] = '{32'd0,  32'd9,         1'b0, 64'h0000};
        v4[2] = '{32'd8,  32'd8,         1'b1, 64'h0040};
        v4[3] = '{32'd8,  32'd7,         1'b1, 64'h00C8};
        v4[4] = '{32'd15, 32'd1,         1'b1, 64'h00FF};
        v4[5] = '{32'd7,  32'd7,         1'b1, 64'h0031};

        // Hand-computed values that pin the reference model.
        for (int i = 0; i < 6; i++)
            check($sformatf("model w4 vec%0d", i), ref_mul(v4[i].x, v4[i].y, v4[i].s, 4), v4[i].p);
        check("model 255*255 u8", ref_mul(32'd255, 32'd255, 1'b0, 8), 64'hFE01);
        check("model -128*-128 s8", ref_mul(32'h80, 32'h80, 1'b1, 8), 64'h4000);
        check("model min*min s32", ref_mul(32'h80000000, 32'h80000000, 1'b1, 32), 64'h4000000000000000);

        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("reset out_valid g%0d", g), 64'(ov_a[g]), 64'd0);
            check($sformatf("reset out_product g%0d", g), prod_a[g], 64'd0);
            check($sformatf("reset in_ready g%0d", g), 64'(rdy_a[g]), 64'd1);
        end
        #9 rst_n = 1'b1;
        step();

        // WIDTH=4, PIPE_STAGES=2 directed vectors and one-cycle latency.
        for (int i = 0; i < 6; i++) begin
            send(v4[i].x, v4[i].y, v4[i].s);
            check($sformatf("w4 vec%0d not yet valid", i), 64'(ov_a[0]), 64'd0);
            step();
            check($sformatf("w4 vec%0d valid", i), 64'(ov_a[0]), 64'd1);
            check($sformatf("w4 vec%0d product", i), prod_a[0], v4[i].p);
        end
        repeat (5) step();

        // WIDTH=8, PIPE_STAGES=3 directed vectors.
        send(32'd255, 32'd255, 1'b0);
        check("w8 255*255 not yet valid", 64'(ov_a[1]), 64'd0);
        step();
        step();
        check("w8 255*255 valid", 64'(ov_a[1]), 64'd1);
        check("w8 255*255 product", prod_a[1], 64'hFE01);
        send(32'h80, 32'h80, 1'b1);
        step();
        step();
        check("w8 -128*-128 product", prod_a[1], 64'h4000);
        repeat (5) step();

        // Back-to-back throughput.
        tp_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            in_x      = (i == 5) ? 32'd255 : $urandom;
            in_y      = (i == 5) ? 32'd255 : $urandom;
            in_signed = (i == 5) ? 1'b0 : 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        repeat (8) step();
        tp_en = 1'b0;
        if (tp_run > tp_best) tp_best = tp_run;
        check("throughput longest out_valid run", 64'(tp_best), 64'd16);
        check("throughput total out_valid", 64'(tp_total), 64'd16);

        // Backpressure: fill every pipeline, keep offering, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_x      = $urandom;
            in_y      = $urandom;
            in_signed = 1'($urandom_range(0, 1));
            step();
        end
        for (int g = 0; g < NI; g++)
            check($sformatf("full in_ready g%0d", g), 64'(rdy_a[g]), 64'd0);
        repeat (3) begin
            in_x = $urandom;
            in_y = $urandom;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();

        // Reset while two beats are in flight.
        in_valid = 1'b1;
        in_x     = 32'd3;
        in_y     = 32'd5;
        step();
        in_x = 32'd6;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("midreset out_valid g%0d", g), 64'(ov_a[g]), 64'd0);
            check($sformatf("midreset out_product g%0d", g), prod_a[g], 64'd0);
            check($sformatf("midreset in_ready g%0d", g), 64'(rdy_a[g]), 64'd1);
        end
        #3 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            for (int g = 0; g < NI; g++)
                check($sformatf("post-reset idle g%0d", g), 64'(ov_a[g]), 64'd0);
        end

        // Random traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_x      = $urandom;
            in_y      = $urandom;
            in_signed = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: in_x = '1;
                1: in_y = '0;
                2: begin in_x = '1; in_y = '1; end
                default: ;
            endcase
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        end_chk = 1'b1;
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_pipe_seq.md
Name: mult_pipe_seq

Overview:
- Parametrised, pipelined successor to the fixed 4-bit combinational multiplier.
- Flow: WIDTH x WIDTH partial-product generation -> HA/FA carry-save compression tree -> final parallel-prefix adder.
- Register stages are spread across this datapath. A valid/ready handshake gives backpressure, and a per-transaction mode selects unsigned or two's-complement operands.
- Sits between operand-issue logic and any downstream consumer that can stall.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- PIPE_STAGES, 2, number of register stages from operand capture to out_product; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  operand beat offered
- in_ready  out  1  block accepts a beat this cycle
- in_x  in  WIDTH  multiplicand
- in_y  in  WIDTH  multiplier
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned
- out_valid  out  1  out_product holds a result
- out_ready  in  1  consumer takes the result this cycle
- out_product  out  2*WIDTH  full-width product

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear; out_valid=0; out_product=0.
  - in_ready is 1 immediately after reset because the pipeline is empty.
  - Internal datapath registers need no reset.
  - Reset mid-operation discards every in-flight beat; no partial result ever appears.
- Advance rule (stall-all pipeline):
  - adv = !out_valid | out_ready; in_ready = adv.
  - When adv=1, every stage shifts one place: stage0 <- input beat; its valid bit <- in_valid.
  - When adv=0, all stages hold data and valid bits.
  - Bubbles are not collapsed while stalled.
- Handshakes:
  - Input beat accepted on an edge with in_valid & in_ready.
  - Output beat consumed on an edge with out_valid & out_ready.
  - in_x, in_y and in_signed are sampled only on acceptance.
- Latency and throughput:
  - Result of a beat accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1, when the consumer never stalls.
  - PIPE_STAGES=1 means out_product is registered directly from the inputs.
  - Throughput is one beat per cycle when out_ready stays high.
  - Results leave in acceptance order.
- Stage mapping:
  - stage0 captures operands and the mode bit.
  - Intermediate stages hold the carry-save sum/carry vectors, each 2*WIDTH bits.
  - The last stage holds the prefix-adder sum.
  - With PIPE_STAGES=1, all logic is combinational into a single register.
- Arithmetic:
  - Unsigned: out_product = in_x * in_y exactly, 2*WIDTH bits, no truncation.
  - Signed: Baugh-Wooley inversion of the MSB-row/column partial products plus correction constants. out_product is the exact 2*WIDTH-bit two's-complement product.
  - -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2), with no overflow.
- Boundaries:
  - Pipeline full and stalled: in_ready=0; all held values stable; out_product unchanged.
  - Simultaneous output consume and input accept on the same edge is legal; both occur.
  - out_product is stable whenever out_valid=1 and out_ready=0.

Optional Feature:
- Macro: MULT_PIPE_CNT_EN.
- Defined:
  - Adds output port done_count, 32 bits.
  - Increments by 1 on each output handshake edge and wraps 0xFFFFFFFF -> 0.
  - Reset to 0 by rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mult_pkg holds:
  - localparam functions: product width = 2*WIDTH; compression-tree row count.
  - typedef for the carry-save pair struct {sum, carry}.
  - Baugh-Wooley correction-constant function of WIDTH.
- Sub-module mult_csa_tree, combinational:
  - Inputs: x, y, signed_mode.
  - Output: 2*WIDTH carry-save pair.
  - Built from HA/FA cells in Dadda order.
- The final prefix adder is inlined in the top level using the existing grey/black cell style.

Test Plan:
- WIDTH=4, PIPE_STAGES=2, unsigned:
  - 15*15 -> 0x00E1
  - 0*9 -> 0x0000
  - out_valid exactly 1 cycle after the accept edge.
- WIDTH=4, signed:
  - -8*-8 -> 0x40
  - -8*7 -> 0xC8
  - -1*1 -> 0xFF
  - 7*7 -> 0x31
- Throughput, WIDTH=8, PIPE_STAGES=3:
  - 16 back-to-back beats with out_ready=1.
  - Expect 16 consecutive out_valid cycles and correct in-order products, e.g. 255*255=0xFE01.
- Backpressure:
  - Hold out_ready=0 and offer 5 beats; in_ready drops once the pipeline is full.
  - out_product stays stable; on release all accepted beats emerge in order with none lost or duplicated.
- Reset mid-flight:
  - Accept 2 beats, pulse rst_n low between edges.
  - out_valid=0 and out_product=0 immediately; no stale result appears afterwards; in_ready=1.
- With MULT_PIPE_CNT_EN:
  - 10 output handshakes with a 3-cycle stall inserted -> done_count=10.
  - Force counter to 0xFFFFFFFF, do 1 handshake -> 0.
